// File: rtl/aimc_lib.sv
// Shared search-mode type, counter width and small helpers for the age-search slice.
package aimc_lib;

  typedef enum logic {
    OLDEST_FIRST   = 1'b0,
    YOUNGEST_FIRST = 1'b1
  } search_mode_e;

  localparam int CNT_W = 16;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/orde_grp_penc.sv
// Group priority encoder over a rotated (distance-ordered) valid slice; purely combinational.
// Oldest-first picks the lowest set bit, youngest-first the highest.
module orde_grp_penc
  import aimc_lib::*;
#(
  parameter int GRP_SIZE = 4,
  localparam int OFS_W = clog2_min1(GRP_SIZE)
) (
  input  logic [GRP_SIZE-1:0] i_vec,
  input  search_mode_e        i_mode,
  output logic                o_vld,
  output logic [OFS_W-1:0]    o_ofs
);

  always_comb begin
    o_vld = |i_vec;
    o_ofs = '0;
    if (i_mode == OLDEST_FIRST) begin
      for (int k = GRP_SIZE - 1; k >= 0; k--) begin
        if (i_vec[k]) o_ofs = OFS_W'(k);
      end
    end else begin
      for (int k = 0; k < GRP_SIZE; k++) begin
        if (i_vec[k]) o_ofs = OFS_W'(k);
      end
    end
  end

endmodule

// File: rtl/orde_l2_age_search.sv
// Age-ordered block search: 3-stage pipeline (capture, per-group encode, output), latency 3.
// Single global enable: every stage stalls while a response is held un-accepted.
module orde_l2_age_search
  import aimc_lib::*;
#(
  parameter int NUM_PER_BLOCK = 32,
  parameter int NUM_MAX_RD    = 512,
  parameter int NUM_BLOCK     = 16,
  parameter int NUM_DIV       = 4,
  localparam int IDX_W = $clog2(NUM_MAX_RD),
  localparam int BLK_W = $clog2(NUM_BLOCK)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [IDX_W-1:0]                 req_oldest_idx,
  input  logic [BLK_W-1:0]                 req_start_ofs,
  input  logic                             req_mode,
  input  logic [NUM_BLOCK-1:0]             req_blk_valid,
  input  logic [NUM_BLOCK-1:0][IDX_W-1:0]  req_blk_idx,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_hit,
  output logic [BLK_W-1:0]                 rsp_blk,
  output logic [IDX_W-1:0]                 rsp_idx,
  output logic [CNT_W-1:0]                 hit_cnt,
  output logic [CNT_W-1:0]                 miss_cnt
);

  localparam int PB_W     = $clog2(NUM_PER_BLOCK);
  localparam int GRP_SIZE = NUM_BLOCK / NUM_DIV;
  localparam int OFS_W    = clog2_min1(GRP_SIZE);

  if (NUM_BLOCK != NUM_MAX_RD / NUM_PER_BLOCK) begin : g_bad_nblk
    $fatal(1, "NUM_BLOCK must equal NUM_MAX_RD/NUM_PER_BLOCK");
  end
  if (NUM_BLOCK % NUM_DIV != 0) begin : g_bad_ndiv
    $fatal(1, "NUM_DIV must divide NUM_BLOCK");
  end

  logic                            w_en;
  logic [BLK_W-1:0]                w_oldest_blk;
  logic [BLK_W-1:0]                w_start;
  logic                            w_unused;

  logic                            r1_vld;
  logic [BLK_W-1:0]                r1_start;
  search_mode_e                    r1_mode;
  logic [NUM_BLOCK-1:0]            r1_blk_valid;
  logic [NUM_BLOCK-1:0][IDX_W-1:0] r1_blk_idx;
  logic [NUM_BLOCK-1:0]            w_rot;
  logic [NUM_DIV-1:0]              w_grp_vld;
  logic [NUM_DIV-1:0][OFS_W-1:0]   w_grp_ofs;

  logic                            r2_vld;
  logic [BLK_W-1:0]                r2_start;
  search_mode_e                    r2_mode;
  logic [NUM_DIV-1:0]              r2_grp_vld;
  logic [NUM_DIV-1:0][OFS_W-1:0]   r2_grp_ofs;
  logic [NUM_BLOCK-1:0][IDX_W-1:0] r2_blk_idx;
  logic                            w_hit;
  logic [BLK_W-1:0]                w_dist;
  logic [BLK_W-1:0]                w_blk;
  logic [IDX_W-1:0]                w_idx;

  logic                            r_rsp_vld;
  logic                            r_rsp_hit;
  logic [BLK_W-1:0]                r_rsp_blk;
  logic [IDX_W-1:0]                r_rsp_idx;
  logic [CNT_W-1:0]                r_hit_cnt;
  logic [CNT_W-1:0]                r_miss_cnt;

  assign w_en         = !r_rsp_vld || rsp_ready;
  assign w_oldest_blk = req_oldest_idx[IDX_W-1:PB_W];
  assign w_start      = w_oldest_blk + req_start_ofs;
  assign w_unused     = ^req_oldest_idx[PB_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_vld       <= 1'b0;
      r1_start     <= '0;
      r1_mode      <= OLDEST_FIRST;
      r1_blk_valid <= '0;
      r1_blk_idx   <= '0;
    end else if (w_en) begin
      r1_vld       <= req_valid;
      r1_start     <= w_start;
      r1_mode      <= search_mode_e'(req_mode);
      r1_blk_valid <= req_blk_valid;
      r1_blk_idx   <= req_blk_idx;
    end
  end

  // Bit k of the rotated vector is the block at distance k from the start block.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < NUM_BLOCK; k++) begin
      w_rot[k] = r1_blk_valid[r1_start + BLK_W'(k)];
    end
  end

  for (genvar g = 0; g < NUM_DIV; g++) begin : g_grp
    orde_grp_penc #(.GRP_SIZE(GRP_SIZE)) u_penc (
      .i_vec  (w_rot[g*GRP_SIZE +: GRP_SIZE]),
      .i_mode (r1_mode),
      .o_vld  (w_grp_vld[g]),
      .o_ofs  (w_grp_ofs[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_vld     <= 1'b0;
      r2_start   <= '0;
      r2_mode    <= OLDEST_FIRST;
      r2_grp_vld <= '0;
      r2_grp_ofs <= '0;
      r2_blk_idx <= '0;
    end else if (w_en) begin
      r2_vld     <= r1_vld;
      r2_start   <= r1_start;
      r2_mode    <= r1_mode;
      r2_grp_vld <= w_grp_vld;
      r2_grp_ofs <= w_grp_ofs;
      r2_blk_idx <= r1_blk_idx;
    end
  end

  always_comb begin
    w_hit  = 1'b0;
    w_dist = '0;
    if (r2_mode == OLDEST_FIRST) begin
      for (int g = NUM_DIV - 1; g >= 0; g--) begin
        if (r2_grp_vld[g]) begin
          w_hit  = 1'b1;
          w_dist = BLK_W'(g * GRP_SIZE) + BLK_W'(r2_grp_ofs[g]);
        end
      end
    end else begin
      for (int g = 0; g < NUM_DIV; g++) begin
        if (r2_grp_vld[g]) begin
          w_hit  = 1'b1;
          w_dist = BLK_W'(g * GRP_SIZE) + BLK_W'(r2_grp_ofs[g]);
        end
      end
    end
    // Undo the rotation to recover the physical block number.
    w_blk = w_hit ? w_dist + r2_start : '0;
    w_idx = w_hit ? r2_blk_idx[w_blk] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld <= 1'b0;
      r_rsp_hit <= 1'b0;
      r_rsp_blk <= '0;
      r_rsp_idx <= '0;
    end else if (w_en) begin
      r_rsp_vld <= r2_vld;
      r_rsp_hit <= w_hit;
      r_rsp_blk <= w_blk;
      r_rsp_idx <= w_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_rsp_vld && rsp_ready) begin
      if (r_rsp_hit) r_hit_cnt  <= cnt_sat_inc(r_hit_cnt);
      else           r_miss_cnt <= cnt_sat_inc(r_miss_cnt);
    end
  end

  assign req_ready = w_en;
  assign rsp_valid = r_rsp_vld;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_blk   = r_rsp_blk;
  assign rsp_idx   = r_rsp_idx;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_orde_l2_age_search.sv
// Bench for orde_l2_age_search: distance-based reference model with per-cycle scoreboard
// plus directed vectors carrying hand-computed block numbers.
module tb_orde_l2_age_search;

  typedef struct packed {
    logic       hit;
    logic [3:0] blk;
    logic [8:0] idx;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [8:0]        req_oldest_idx;
  logic [3:0]        req_start_ofs;
  logic              req_mode;
  logic [15:0]       req_blk_valid;
  logic [15:0][8:0]  req_blk_idx;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [3:0]        rsp_blk;
  logic [8:0]        rsp_idx;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  int          checks = 0;
  int          failures = 0;
  int          seed = 0;
  exp_t        q[$];
  logic [15:0] m_hit, m_miss;
  logic        p_stall, p_hit;
  logic [3:0]  p_blk;
  logic [8:0]  p_idx;

  orde_l2_age_search dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_oldest_idx (req_oldest_idx),
    .req_start_ofs  (req_start_ofs),
    .req_mode       (req_mode),
    .req_blk_valid  (req_blk_valid),
    .req_blk_idx    (req_blk_idx),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_hit        (rsp_hit),
    .rsp_blk        (rsp_blk),
    .rsp_idx        (rsp_idx),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Walk distances 0..15 from the start block; oldest keeps the first valid, youngest the last.
  function automatic exp_t model(input logic [8:0] oldest, input logic [3:0] ofs, input logic mode,
                                 input logic [15:0] v, input logic [15:0][8:0] idx);
    exp_t e;
    int   s;
    e = '0;
    s = (int'(oldest >> 5) + int'(ofs)) % 16;
    for (int d = 0; d < 16; d++) begin
      int b;
      b = (s + d) % 16;
      if (v[b] && (!e.hit || mode)) begin
        e.hit = 1'b1;
        e.blk = 4'(b);
        e.idx = idx[b];
      end
    end
    return e;
  endfunction

  function automatic logic [15:0][8:0] fill(input int sd);
    logic [15:0][8:0] f;
    for (int b = 0; b < 16; b++) f[b] = 9'(b * 32 + (b * 7 + sd * 3) % 32);
    return f;
  endfunction

  task automatic run_one(input string name, input logic [8:0] old, input logic [3:0] ofs,
                         input logic mode, input logic [15:0] v, input logic eh, input logic [3:0] eb);
    logic [15:0][8:0] tbl;
    int lat;
    seed++;
    tbl            = fill(seed);
    req_blk_idx    = tbl;
    req_oldest_idx = old;
    req_start_ofs  = ofs;
    req_mode       = mode;
    req_blk_valid  = v;
    req_valid      = 1'b1;
    @(posedge clk); #1;
    req_valid      = 1'b0;
    req_blk_idx    = fill(seed + 100);
    req_oldest_idx = ~old;
    req_start_ofs  = ~ofs;
    req_mode       = ~mode;
    req_blk_valid  = ~v;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_hit"}, rsp_hit, eh);
    chk({name, "_blk"}, rsp_blk, eb);
    chk({name, "_idx"}, rsp_idx, eh ? tbl[eb] : 9'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_req(input logic [8:0] old, input logic [3:0] ofs, input logic mode,
                          input logic [15:0] v, input int sd);
    logic acc;
    int   n;
    req_oldest_idx = old;
    req_start_ofs  = ofs;
    req_mode       = mode;
    req_blk_valid  = v;
    req_blk_idx    = fill(sd);
    req_valid      = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    chk("push_accept", acc, 1);
    req_valid = 1'b0;
  endtask

  initial begin
    int stale, n;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; req_mode = 1'b0;
    req_oldest_idx = '0; req_start_ofs = '0; req_blk_valid = '0; req_blk_idx = fill(0);
    m_hit = '0; m_miss = '0; p_stall = 1'b0; p_hit = 1'b0; p_blk = '0; p_idx = '0;

    // Scoreboard: counters every cycle, response contents on handshake, hold while stalled.
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
          m_hit = '0; m_miss = '0; p_stall = 1'b0;
        end else begin
          chk("sb_hit_cnt", hit_cnt, m_hit);
          chk("sb_miss_cnt", miss_cnt, m_miss);
          if (p_stall) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_hit", rsp_hit, p_hit);
            chk("hold_blk", rsp_blk, p_blk);
            chk("hold_idx", rsp_idx, p_idx);
          end
          if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_rsp: got rsp blk=%0d idx=0x%0h expected no response", rsp_blk, rsp_idx);
            end else begin
              exp_t e;
              e = q.pop_front();
              chk("sb_hit", rsp_hit, e.hit);
              chk("sb_blk", rsp_blk, e.blk);
              chk("sb_idx", rsp_idx, e.idx);
            end
            if (rsp_hit) begin if (m_hit != 16'hFFFF) m_hit++; end
            else begin if (m_miss != 16'hFFFF) m_miss++; end
          end
          if (req_valid && req_ready)
            q.push_back(model(req_oldest_idx, req_start_ofs, req_mode, req_blk_valid, req_blk_idx));
          p_stall = rsp_valid && !rsp_ready;
          p_hit = rsp_hit; p_blk = rsp_blk; p_idx = rsp_idx;
        end
      end
    join_none

    repeat (2) @(posedge clk); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst_n = 1'b1;
    chk("rst_req_ready", req_ready, 1);

    run_one("a5_m0",     9'h0A5, 4'd0,  1'b0, 16'h1084, 1'b1, 4'd7);
    run_one("a5_m1",     9'h0A5, 4'd0,  1'b1, 16'h1084, 1'b1, 4'd2);
    run_one("a5_o3_m0",  9'h0A5, 4'd3,  1'b0, 16'h1084, 1'b1, 4'd12);
    run_one("a5_o3_m1",  9'h0A5, 4'd3,  1'b1, 16'h1084, 1'b1, 4'd7);
    run_one("wrap_m0",   9'h1E0, 4'd1,  1'b0, 16'h8001, 1'b1, 4'd0);
    run_one("wrap_m1",   9'h1E0, 4'd1,  1'b1, 16'h8001, 1'b1, 4'd15);
    run_one("none_m0",   9'h0A5, 4'd0,  1'b0, 16'h0000, 1'b0, 4'd0);
    run_one("none_m1",   9'h123, 4'd7,  1'b1, 16'h0000, 1'b0, 4'd0);
    run_one("single",    9'h13F, 4'd15, 1'b0, 16'h0100, 1'b1, 4'd8);
    run_one("all_m0",    9'h040, 4'd0,  1'b0, 16'hFFFF, 1'b1, 4'd2);
    run_one("all_m1",    9'h040, 4'd0,  1'b1, 16'hFFFF, 1'b1, 4'd1);
    run_one("grp_m0",    9'h000, 4'd0,  1'b0, 16'h0018, 1'b1, 4'd3);
    run_one("grp_m1",    9'h000, 4'd0,  1'b1, 16'h0018, 1'b1, 4'd4);
    chk("lit_hit_cnt", hit_cnt, 11);
    chk("lit_miss_cnt", miss_cnt, 2);

    // Back-to-back stream with a 5-cycle consumer stall in the middle.
    fork
      begin
        for (int i = 0; i < 10; i++)
          push_req(9'(i * 37), 4'(i * 5), 1'(i),
                   (i == 6) ? 16'h0000 : ((16'h0001 << i) | (16'h8000 >> ((i * 3) % 16))), i + 200);
      end
      begin
        repeat (4) @(posedge clk); #1;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("stall_req_ready", req_ready, 0);
        repeat (2) @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    n = 0;
    while ((q.size() != 0 || rsp_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);

    req_blk_valid = '0;
    req_valid = 1'b1;
    repeat (65600) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("miss_saturated", miss_cnt, 16'hFFFF);

    // Reset with three requests in flight.
    for (int i = 0; i < 3; i++) push_req(9'h0A5, 4'(i), 1'b0, 16'h1084, 300 + i);
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_hit", rsp_hit, 0);
    chk("arst_rsp_blk", rsp_blk, 0);
    chk("arst_rsp_idx", rsp_idx, 0);
    chk("arst_hit_cnt", hit_cnt, 0);
    chk("arst_miss_cnt", miss_cnt, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    chk("arst_req_ready", req_ready, 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("arst_no_stale", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
